// File: rtl/spi_bridge_pkg.sv
// Shared types and command-word field positions for the SPI-to-register bridge.
package spi_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_BURST,
    DRAIN
  } state_e;

  localparam int CMD_WR_BIT  = 15;
  localparam int CMD_CNT_MSB = 14;
  localparam int CMD_CNT_LSB = 8;

  localparam logic [15:0] STATUS_WORD_DEF = 16'hA55A;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Local register bus between the bridge (master) and the register file (slave).
interface spi_reg_bridge_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] reg_addr;
  logic [15:0]       reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [15:0]       reg_rdata;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/spi_reg_bridge_sync_2ff.sv
// Two-flop synchronizer with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/spi_reg_bridge.sv
// Decodes SPI command words into auto-incrementing register read/write bursts;
// read data is returned one SPI word late because the shifter latches tx_data at word end.
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter logic [15:0] STATUS_WORD = STATUS_WORD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              rx_done,
  input  logic [15:0]       rx_data,
  output logic [15:0]       tx_data,
  spi_reg_bridge_if.master  bus,
  output logic              busy
);

  logic ss_s;

  sync_2ff #(.RST_VAL(1'b1)) u_ss_sync (
    .clk (clk),
    .rst (rst),
    .d   (ss),
    .q   (ss_s)
  );

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;
  logic [7:0]        remaining_q, remaining_d;
  logic [15:0]       tx_data_q, tx_data_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [15:0]       reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              cap_pend_q, cap_pend_d;

  logic [ADDR_W-1:0] cmd_addr;
  logic [6:0]        cmd_cnt_m1;

  assign cmd_addr   = rx_data[ADDR_W-1:0];
  assign cmd_cnt_m1 = rx_data[CMD_CNT_MSB:CMD_CNT_LSB];

  always_comb begin
    state_d     = state_q;
    addr_ptr_d  = addr_ptr_q;
    remaining_d = remaining_q;
    tx_data_d   = tx_data_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    // reg_rdata is valid the cycle after the strobe, so capture one cycle later
    cap_pend_d  = reg_re_q;

    if (cap_pend_q) tx_data_d = bus.reg_rdata;

    // Deselect beats everything, including a word completing in the same cycle
    if (ss_s) begin
      state_d    = IDLE;
      cap_pend_d = 1'b0;
      tx_data_d  = STATUS_WORD;
    end else if (rx_done) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data[CMD_WR_BIT]) begin
            state_d     = WR_BURST;
            addr_ptr_d  = cmd_addr;
            remaining_d = 8'(cmd_cnt_m1) + 8'd1;
          end else begin
            // first read goes out straight from the command word
            state_d     = RD_BURST;
            reg_re_d    = 1'b1;
            reg_addr_d  = cmd_addr;
            addr_ptr_d  = cmd_addr + ADDR_W'(1);
            remaining_d = 8'(cmd_cnt_m1);
          end
        end
        WR_BURST: begin
          reg_we_d    = 1'b1;
          reg_wdata_d = rx_data;
          reg_addr_d  = addr_ptr_q;
          addr_ptr_d  = addr_ptr_q + ADDR_W'(1);
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) state_d = DRAIN;
        end
        RD_BURST: begin
          if (remaining_q != 8'd0) begin
            reg_re_d    = 1'b1;
            reg_addr_d  = addr_ptr_q;
            addr_ptr_d  = addr_ptr_q + ADDR_W'(1);
            remaining_d = remaining_q - 8'd1;
          end else begin
            state_d = DRAIN;
          end
        end
        DRAIN: tx_data_d = STATUS_WORD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_ptr_q  <= '0;
      remaining_q <= '0;
      tx_data_q   <= STATUS_WORD;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      cap_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_ptr_q  <= addr_ptr_d;
      remaining_q <= remaining_d;
      tx_data_q   <= tx_data_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      cap_pend_q  <= cap_pend_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_re    = reg_re_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scenario bench for spi_reg_bridge: register-file model, write/tx scoreboards.
module tb_spi_reg_bridge;

  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ss = 1'b1;
  logic        rx_done = 1'b0;
  logic [15:0] rx_data = '0;
  logic [15:0] tx_data;
  logic        busy;

  spi_reg_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  spi_reg_bridge #(.ADDR_W(ADDR_W), .STATUS_WORD(16'hA55A)) dut (
    .clk     (clk),
    .rst     (rst),
    .ss      (ss),
    .rx_done (rx_done),
    .rx_data (rx_data),
    .tx_data (tx_data),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // register file model: read data valid the cycle after reg_re
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
    else            bus.reg_rdata <= 16'h0000;
  end

  // observed side of the scoreboards
  logic [23:0] obs_wr[$];
  logic [15:0] obs_tx[$];
  int          re_cnt = 0;
  int          both_cnt = 0;
  always @(negedge clk) begin
    if (bus.reg_we) obs_wr.push_back({bus.reg_addr, bus.reg_wdata});
    if (bus.reg_re) re_cnt++;
    if (bus.reg_we && bus.reg_re) both_cnt++;
    if (rx_done) obs_tx.push_back(tx_data);
  end

  logic [23:0] exp_wr[$];
  logic [15:0] exp_tx[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic [15:0] w);
    rx_data = w;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    repeat (6) tick();
  endtask

  task automatic ss_low();
    ss = 1'b0;
    repeat (3) tick();
  endtask

  task automatic clear_sb();
    obs_wr.delete(); exp_wr.delete();
    obs_tx.delete(); exp_tx.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_checks++; if (tx_data !== 16'hA55A) $display("FAIL reset_tx got %h want a55a", tx_data); else n_pass++;
    n_checks++; if (bus.reg_addr !== 8'h00) $display("FAIL reset_addr got %h want 00", bus.reg_addr); else n_pass++;
    n_checks++; if (bus.reg_wdata !== 16'h0) $display("FAIL reset_wdata got %h want 0000", bus.reg_wdata); else n_pass++;
    n_checks++; if (bus.reg_we !== 1'b0) $display("FAIL reset_we got %b want 0", bus.reg_we); else n_pass++;
    n_checks++; if (bus.reg_re !== 1'b0) $display("FAIL reset_re got %b want 0", bus.reg_re); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_write_burst();
    clear_sb();
    ss_low();
    exp_wr.push_back({8'h80, 16'h1111});
    exp_wr.push_back({8'h81, 16'h2222});
    exp_wr.push_back({8'h82, 16'h3333});
    repeat (4) exp_tx.push_back(16'hA55A);
    send_word(16'h8280);
    n_checks++; if (busy !== 1'b1) $display("FAIL wr_busy_open got %b want 1", busy); else n_pass++;
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    ss = 1'b1;
    repeat (2) tick();
    n_checks++; if (busy !== 1'b1) $display("FAIL wr_busy_2clk got %b want 1", busy); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL wr_busy_3clk got %b want 0", busy); else n_pass++;
    n_checks++;
    if (obs_wr.size() != exp_wr.size()) $display("FAIL wr_count got %0d want %0d", obs_wr.size(), exp_wr.size());
    else n_pass++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      logic [23:0] e, o;
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      n_checks++; if (o !== e) $display("FAIL wr_data got %h want %h", o, e); else n_pass++;
    end
    while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
      logic [15:0] e, o;
      e = exp_tx.pop_front(); o = obs_tx.pop_front();
      n_checks++; if (o !== e) $display("FAIL wr_tx got %h want %h", o, e); else n_pass++;
    end
  endtask

  task automatic test_read_burst();
    int re0;
    clear_sb();
    mem[8'h10] = 16'hBEEF;
    mem[8'h11] = 16'hCAFE;
    mem[8'h12] = 16'h1234;
    re0 = re_cnt;
    ss_low();
    exp_tx.push_back(16'hA55A);
    exp_tx.push_back(16'hBEEF);
    exp_tx.push_back(16'hCAFE);
    exp_tx.push_back(16'hCAFE);
    send_word(16'h0110);
    for (int i = 0; i < 3; i++) send_word(16'h0000 + 16'(i));
    n_checks++; if (tx_data !== 16'hA55A) $display("FAIL rd_tx_drain got %h want a55a", tx_data); else n_pass++;
    n_checks++; if (re_cnt - re0 != 2) $display("FAIL rd_re_count got %0d want 2", re_cnt - re0); else n_pass++;
    n_checks++;
    if (obs_tx.size() != exp_tx.size()) $display("FAIL rd_tx_count got %0d want %0d", obs_tx.size(), exp_tx.size());
    else n_pass++;
    while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
      logic [15:0] e, o;
      e = exp_tx.pop_front(); o = obs_tx.pop_front();
      n_checks++; if (o !== e) $display("FAIL rd_tx got %h want %h", o, e); else n_pass++;
    end
    ss = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    clear_sb();
    ss_low();
    exp_wr.push_back({8'hFF, 16'hAAAA});
    exp_wr.push_back({8'h00, 16'hBBBB});
    send_word(16'h81FF);
    send_word(16'hAAAA);
    send_word(16'hBBBB);
    ss = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (obs_wr.size() != exp_wr.size()) $display("FAIL wrap_count got %0d want %0d", obs_wr.size(), exp_wr.size());
    else n_pass++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      logic [23:0] e, o;
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      n_checks++; if (o !== e) $display("FAIL wrap_data got %h want %h", o, e); else n_pass++;
    end
  endtask

  task automatic test_abort();
    int re0;
    clear_sb();
    for (int i = 0; i < 4; i++) mem[8'h40 + i] = 16'h4000 + 16'(i);
    re0 = re_cnt;
    ss_low();
    send_word(16'h0340);
    rx_data = 16'h0001;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    ss = 1'b1;
    repeat (5) tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (tx_data !== 16'hA55A) $display("FAIL abort_tx got %h want a55a", tx_data); else n_pass++;
    send_word(16'h8000);
    n_checks++; if (re_cnt - re0 != 2) $display("FAIL abort_re_count got %0d want 2", re_cnt - re0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_ss_high_busy got %b want 0", busy); else n_pass++;
    ss_low();
    exp_wr.push_back({8'h50, 16'h5555});
    exp_wr.push_back({8'h51, 16'h6666});
    send_word(16'h8150);
    send_word(16'h5555);
    send_word(16'h6666);
    ss = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (obs_wr.size() != exp_wr.size()) $display("FAIL abort_next_count got %0d want %0d", obs_wr.size(), exp_wr.size());
    else n_pass++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      logic [23:0] e, o;
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      n_checks++; if (o !== e) $display("FAIL abort_next_data got %h want %h", o, e); else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    clear_sb();
    ss_low();
    exp_wr.push_back({8'h60, 16'h7777});
    send_word(16'h8260);
    send_word(16'h7777);
    ss = 1'b1;
    repeat (2) tick();
    // synchronized ss is high now; this word lands in the abort cycle
    rx_data = 16'hDEAD;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (obs_wr.size() != exp_wr.size()) $display("FAIL simul_count got %0d want %0d", obs_wr.size(), exp_wr.size());
    else n_pass++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      logic [23:0] e, o;
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      n_checks++; if (o !== e) $display("FAIL simul_data got %h want %h", o, e); else n_pass++;
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL simul_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 4; i++) mem[8'h70 + i] = 16'h7000 + 16'(i);
    ss_low();
    send_word(16'h0370);
    rx_data = 16'h0001;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before got %b want 1", busy); else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++; if (tx_data !== 16'hA55A) $display("FAIL rstmid_tx got %h want a55a", tx_data); else n_pass++;
    n_checks++; if (bus.reg_addr !== 8'h00) $display("FAIL rstmid_addr got %h want 00", bus.reg_addr); else n_pass++;
    n_checks++; if (bus.reg_re !== 1'b0) $display("FAIL rstmid_re got %b want 0", bus.reg_re); else n_pass++;
    n_checks++; if (bus.reg_we !== 1'b0) $display("FAIL rstmid_we got %b want 0", bus.reg_we); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else n_pass++;
    rst = 1'b0;
    ss = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000 + 16'(i);
    tick();
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_abort();
    test_simultaneous();
    test_reset_mid_burst();
    n_checks++; if (both_cnt != 0) $display("FAIL we_re_overlap got %0d want 0", both_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
